// File: rtl/adder_pkg.sv
// Shared constants and the signed-overflow helper for the adder trio.
package adder_pkg;

  localparam int N_DEFAULT   = 32;
  localparam int BLK_DEFAULT = 4;

  // Two's complement overflow of a+b(+cin): operands agree in sign, result does not.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/cla_block.sv
// BLK-bit carry-lookahead group: flattened lookahead carries plus group generate/propagate.
module cla_block
  import adder_pkg::*;
#(
  parameter int BLK = BLK_DEFAULT
) (
  input  logic [BLK-1:0] i_a,
  input  logic [BLK-1:0] i_b,
  input  logic           i_cin,
  output logic [BLK-1:0] o_sum,
  output logic           o_cout,
  output logic           o_g,
  output logic           o_p,
  output logic           o_c_msb
);

  logic [BLK-1:0] w_g;
  logic [BLK-1:0] w_p;
  logic [BLK:0]   w_c;
  logic           w_grp_g;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Each carry is a sum of products of g/p terms, so no bit waits on its neighbour.
  always_comb begin
    logic w_t;
    w_t     = 1'b0;
    w_c     = '0;
    w_grp_g = 1'b0;
    for (int i = 0; i <= BLK; i++) begin
      w_t = i_cin;
      for (int k = 0; k < i; k++) w_t = w_t & w_p[k];
      w_c[i] = w_t;
      for (int j = 0; j < i; j++) begin
        w_t = w_g[j];
        for (int k = j + 1; k < i; k++) w_t = w_t & w_p[k];
        w_c[i] = w_c[i] | w_t;
      end
    end
    for (int j = 0; j < BLK; j++) begin
      w_t = w_g[j];
      for (int k = j + 1; k < BLK; k++) w_t = w_t & w_p[k];
      w_grp_g = w_grp_g | w_t;
    end
  end

  assign o_sum   = w_p ^ w_c[BLK-1:0];
  assign o_cout  = w_c[BLK];
  assign o_c_msb = w_c[BLK-1];
  assign o_g     = w_grp_g;
  assign o_p     = &w_p;

endmodule

// File: rtl/adder_trio_core.sv
// Registered a+b through lookahead, carry-save and carry-select adders side by side.
// Handshake: in_valid qualifies a/b/cins for one cycle; out_valid follows one cycle later; no ready, every cycle is accepted.
module adder_trio_core
  import adder_pkg::*;
#(
  parameter int N   = N_DEFAULT,
  parameter int BLK = BLK_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         csave_cin,
  input  logic         csel_cin,
  output logic         out_valid,
  output logic [N-1:0] cla_sum,
  output logic         cla_cout,
  output logic         cla_ovf,
  output logic [N-1:0] csave_sum,
  output logic         csave_cout,
  output logic         csave_ovf,
  output logic [N-1:0] csel_sum,
  output logic         csel_cout,
  output logic         csel_ovf
);

  localparam int NB = N / BLK;

  // Second lookahead level: group carries from group G/P, all in parallel.
  function automatic logic [NB:0] grp_carries(input logic [NB-1:0] g, input logic [NB-1:0] p,
                                              input logic cin);
    logic [NB:0] c;
    logic        t;
    c = '0;
    for (int i = 0; i <= NB; i++) begin
      t = cin;
      for (int k = 0; k < i; k++) t = t & p[k];
      c[i] = t;
      for (int j = 0; j < i; j++) begin
        t = g[j];
        for (int k = j + 1; k < i; k++) t = t & p[k];
        c[i] = c[i] | t;
      end
    end
    return c;
  endfunction

  logic [N-1:0]  w_cla_sum, w_cs_s, w_cs_maj, w_cs_cv, w_cs_sum, w_csel_sum;
  logic [NB-1:0] w_cla_g, w_cla_p, w_cla_bc, w_cla_cm;
  logic [NB-1:0] w_cpa_g, w_cpa_p, w_cpa_bc, w_cpa_cm;
  logic [NB:0]   w_cla_gc, w_cpa_gc;
  logic [NB-1:0][BLK-1:0] w_csel_s0, w_csel_s1;
  logic [NB-1:0] w_csel_co0, w_csel_co1, w_csel_cm0, w_csel_cm1;
  logic [NB-1:0] w_csel_g0, w_csel_p0, w_csel_g1, w_csel_p1;
  logic [N-1:0]  w_cs_c3;
  logic          w_csel_cout, w_csel_cm;
  logic          w_unused;

  assign w_cs_c3  = {{(N-1){1'b0}}, csave_cin};
  assign w_cs_s   = a ^ b ^ w_cs_c3;
  assign w_cs_maj = (a & b) | (a & w_cs_c3) | (b & w_cs_c3);
  assign w_cs_cv  = {w_cs_maj[N-2:0], 1'b0};

  assign w_cla_gc = grp_carries(w_cla_g, w_cla_p, 1'b0);
  assign w_cpa_gc = grp_carries(w_cpa_g, w_cpa_p, 1'b0);

  for (genvar k = 0; k < NB; k++) begin : g_blk
    cla_block #(.BLK(BLK)) u_cla (
      .i_a(a[k*BLK +: BLK]), .i_b(b[k*BLK +: BLK]), .i_cin(w_cla_gc[k]),
      .o_sum(w_cla_sum[k*BLK +: BLK]), .o_cout(w_cla_bc[k]),
      .o_g(w_cla_g[k]), .o_p(w_cla_p[k]), .o_c_msb(w_cla_cm[k])
    );
    cla_block #(.BLK(BLK)) u_cpa (
      .i_a(w_cs_s[k*BLK +: BLK]), .i_b(w_cs_cv[k*BLK +: BLK]), .i_cin(w_cpa_gc[k]),
      .o_sum(w_cs_sum[k*BLK +: BLK]), .o_cout(w_cpa_bc[k]),
      .o_g(w_cpa_g[k]), .o_p(w_cpa_p[k]), .o_c_msb(w_cpa_cm[k])
    );
    cla_block #(.BLK(BLK)) u_sel0 (
      .i_a(a[k*BLK +: BLK]), .i_b(b[k*BLK +: BLK]), .i_cin((k == 0) ? csel_cin : 1'b0),
      .o_sum(w_csel_s0[k]), .o_cout(w_csel_co0[k]),
      .o_g(w_csel_g0[k]), .o_p(w_csel_p0[k]), .o_c_msb(w_csel_cm0[k])
    );
    if (k == 0) begin : g_first
      assign w_csel_s1[k]  = '0;
      assign w_csel_co1[k] = 1'b0;
      assign w_csel_cm1[k] = 1'b0;
      assign w_csel_g1[k]  = 1'b0;
      assign w_csel_p1[k]  = 1'b0;
    end else begin : g_pair
      cla_block #(.BLK(BLK)) u_sel1 (
        .i_a(a[k*BLK +: BLK]), .i_b(b[k*BLK +: BLK]), .i_cin(1'b1),
        .o_sum(w_csel_s1[k]), .o_cout(w_csel_co1[k]),
        .o_g(w_csel_g1[k]), .o_p(w_csel_p1[k]), .o_c_msb(w_csel_cm1[k])
      );
    end
  end

  // Block 0 already saw csel_cin, so its carry-0 copy is always the right one.
  always_comb begin
    logic w_sel_c;
    w_sel_c    = csel_cin;
    w_csel_sum = '0;
    w_csel_cm  = 1'b0;
    for (int k = 0; k < NB; k++) begin
      if (k == 0 || !w_sel_c) begin
        w_csel_sum[k*BLK +: BLK] = w_csel_s0[k];
        w_csel_cm                = w_csel_cm0[k];
        w_sel_c                  = w_csel_co0[k];
      end else begin
        w_csel_sum[k*BLK +: BLK] = w_csel_s1[k];
        w_csel_cm                = w_csel_cm1[k];
        w_sel_c                  = w_csel_co1[k];
      end
    end
    w_csel_cout = w_sel_c;
  end

  assign w_unused = ^{w_cla_bc, w_cpa_bc, w_cpa_cm, w_csel_g0, w_csel_p0, w_csel_g1, w_csel_p1,
                      w_cla_g, w_cla_p, w_cpa_g, w_cpa_p};

  logic         r_valid;
  logic [N-1:0] r_cla_sum, r_csave_sum, r_csel_sum;
  logic         r_cla_cout, r_cla_ovf, r_csave_cout, r_csave_ovf, r_csel_cout, r_csel_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_cla_sum    <= '0;
      r_cla_cout   <= 1'b0;
      r_cla_ovf    <= 1'b0;
      r_csave_sum  <= '0;
      r_csave_cout <= 1'b0;
      r_csave_ovf  <= 1'b0;
      r_csel_sum   <= '0;
      r_csel_cout  <= 1'b0;
      r_csel_ovf   <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_cla_sum    <= w_cla_sum;
        r_cla_cout   <= w_cla_gc[NB];
        r_cla_ovf    <= w_cla_cm[NB-1] ^ w_cla_gc[NB];
        r_csave_sum  <= w_cs_sum;
        r_csave_cout <= w_cpa_gc[NB] | w_cs_maj[N-1];
        r_csave_ovf  <= signed_ovf(a[N-1], b[N-1], w_cs_sum[N-1]);
        r_csel_sum   <= w_csel_sum;
        r_csel_cout  <= w_csel_cout;
        r_csel_ovf   <= w_csel_cm ^ w_csel_cout;
      end
    end
  end

  assign out_valid  = r_valid;
  assign cla_sum    = r_cla_sum;
  assign cla_cout   = r_cla_cout;
  assign cla_ovf    = r_cla_ovf;
  assign csave_sum  = r_csave_sum;
  assign csave_cout = r_csave_cout;
  assign csave_ovf  = r_csave_ovf;
  assign csel_sum   = r_csel_sum;
  assign csel_cout  = r_csel_cout;
  assign csel_ovf   = r_csel_ovf;

endmodule

// File: tb/tb_adder_trio_core.sv
// Directed and randomized checks of adder_trio_core against hand-computed and modelled sums.
module tb_adder_trio_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] a, b;
  logic        csave_cin, csel_cin;
  logic        out_valid;
  logic [31:0] cla_sum, csave_sum, csel_sum;
  logic        cla_cout, cla_ovf, csave_cout, csave_ovf, csel_cout, csel_ovf;

  int n_pass = 0;
  int n_total = 0;
  logic [33:0] exp_q[$];

  always #5 clk = ~clk;

  adder_trio_core dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .csave_cin(csave_cin), .csel_cin(csel_cin), .out_valid(out_valid),
    .cla_sum(cla_sum), .cla_cout(cla_cout), .cla_ovf(cla_ovf),
    .csave_sum(csave_sum), .csave_cout(csave_cout), .csave_ovf(csave_ovf),
    .csel_sum(csel_sum), .csel_cout(csel_cout), .csel_ovf(csel_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Drive one cycle of inputs at the falling edge, then sample just after the rising edge.
  task automatic step(input logic v, input logic r, input logic [31:0] va, input logic [31:0] vb,
                      input logic cs, input logic cl);
    @(negedge clk);
    in_valid = v; rst = r; a = va; b = vb; csave_cin = cs; csel_cin = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic ov,
                         input logic [31:0] s0, input logic c0, input logic o0,
                         input logic [31:0] s1, input logic c1, input logic o1,
                         input logic [31:0] s2, input logic c2, input logic o2);
    chk({tag, ".valid"}, {31'b0, out_valid}, {31'b0, ov});
    chk({tag, ".cla_sum"}, cla_sum, s0);
    chk({tag, ".cla_cout"}, {31'b0, cla_cout}, {31'b0, c0});
    chk({tag, ".cla_ovf"}, {31'b0, cla_ovf}, {31'b0, o0});
    chk({tag, ".csave_sum"}, csave_sum, s1);
    chk({tag, ".csave_cout"}, {31'b0, csave_cout}, {31'b0, c1});
    chk({tag, ".csave_ovf"}, {31'b0, csave_ovf}, {31'b0, o1});
    chk({tag, ".csel_sum"}, csel_sum, s2);
    chk({tag, ".csel_cout"}, {31'b0, csel_cout}, {31'b0, c2});
    chk({tag, ".csel_ovf"}, {31'b0, csel_ovf}, {31'b0, o2});
  endtask

  task automatic vec(input string tag, input logic [31:0] va, input logic [31:0] vb,
                     input logic [31:0] s, input logic c, input logic o);
    step(1'b1, 1'b0, va, vb, 1'b0, 1'b0);
    chk_all(tag, 1'b1, s, c, o, s, c, o, s, c, o);
  endtask

  // {ovf, cout, sum} of a+b+cin computed from a wide sum.
  function automatic logic [33:0] model(input logic [31:0] va, input logic [31:0] vb, input logic cin);
    logic [32:0] s;
    logic        o;
    s = {1'b0, va} + {1'b0, vb} + {32'b0, cin};
    o = (va[31] == vb[31]) && (s[31] != va[31]);
    return {o, s};
  endfunction

  initial begin
    logic [31:0] ra, rb;
    logic        rcs, rcl;
    logic [33:0] e0, e1, e2;
    in_valid = 0; rst = 1; a = 0; b = 0; csave_cin = 0; csel_cin = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    vec("20+30", 32'd20, 32'd30, 32'd50, 1'b0, 1'b0);
    vec("-100+-423", 32'hFFFFFF9C, 32'hFFFFFE59, 32'hFFFFFDF5, 1'b1, 1'b0);
    vec("40+-50", 32'd40, 32'hFFFFFFCE, 32'hFFFFFFF6, 1'b0, 1'b0);
    vec("pos_ovf", 32'h7FFFFFF8, 32'd10, 32'h80000002, 1'b0, 1'b1);
    vec("neg_ovf", 32'h80000008, 32'hFFFFFFF6, 32'h7FFFFFFE, 1'b1, 1'b1);
    vec("-40+40", 32'hFFFFFFD8, 32'd40, 32'h0, 1'b1, 1'b0);
    vec("422+-200", 32'd422, 32'hFFFFFF38, 32'd222, 1'b1, 1'b0);
    vec("0+1456", 32'd0, 32'd1456, 32'd1456, 1'b0, 1'b0);

    step(1'b1, 1'b0, 32'h7FFFFFFF, 32'h0, 1'b1, 1'b1);
    chk_all("max+cin", 1'b1, 32'h7FFFFFFF, 0, 0, 32'h80000000, 0, 1, 32'h80000000, 0, 1);

    step(1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0);
    chk_all("m1+cin_split", 1'b1, 32'hFFFFFFFF, 0, 0, 32'h0, 1, 0, 32'hFFFFFFFF, 0, 0);

    step(1'b1, 1'b0, 32'h0000FFFF, 32'h0000FFF0, 1'b0, 1'b1);
    chk_all("csel_cin_only", 1'b1, 32'h0001FFEF, 0, 0, 32'h0001FFEF, 0, 0, 32'h0001FFF0, 0, 0);

    step(1'b0, 1'b0, 32'h12345678, 32'h11111111, 1'b1, 1'b1);
    chk_all("hold", 1'b0, 32'h0001FFEF, 0, 0, 32'h0001FFEF, 0, 0, 32'h0001FFF0, 0, 0);

    step(1'b1, 1'b1, 32'h12345678, 32'h11111111, 1'b1, 1'b1);
    chk_all("rst_mid", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      ra  = $urandom();
      rb  = $urandom();
      rcs = 1'($urandom_range(0, 1));
      rcl = 1'($urandom_range(0, 1));
      if (i % 4 == 0) ra = {~rb[31], $urandom_range(0, 1) ? 31'h7FFFFFFF : 31'h0};
      exp_q.push_back(model(ra, rb, 1'b0));
      exp_q.push_back(model(ra, rb, rcs));
      exp_q.push_back(model(ra, rb, rcl));
      step(1'b1, 1'b0, ra, rb, rcs, rcl);
      e0 = exp_q.pop_front();
      e1 = exp_q.pop_front();
      e2 = exp_q.pop_front();
      chk_all("rand", 1'b1, e0[31:0], e0[32], e0[33], e1[31:0], e1[32], e1[33],
              e2[31:0], e2[32], e2[33]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
